// File: rtl/column_approx_div_if.sv
// column_approx_div_if: start/done request bus between a divider client and column_approx_div.
// master drives the operands and start; slave returns busy/done and the held result.
// Widths follow LENGTH: dividend and quotient are 2*LENGTH bits, divisor and remainder LENGTH bits.
interface column_approx_div_if #(
  parameter int LENGTH = 8
);
  logic                  start;
  logic [2*LENGTH-1:0]   x;
  logic [LENGTH-1:0]     y;
  logic                  busy;
  logic                  done;
  logic [2*LENGTH-1:0]   q;
  logic [LENGTH-1:0]     r;
  logic                  dbz;

  modport master (
    output start, x, y,
    input  busy, done, q, r, dbz
  );

  modport slave (
    input  start, x, y,
    output busy, done, q, r, dbz
  );
endinterface

// File: rtl/column_approx_div.sv
// column_approx_div: radix-2 restoring divider, 2*LENGTH-bit dividend / LENGTH-bit divisor,
// with the low THETA quotient bits decided by a column-truncated trial compare.
// Latency: 2*LENGTH+1 cycles from accepted start to done (1 cycle on divide-by-zero).
// Backpressure: start is sampled only while idle; starts during RUN/DONE are dropped.
// Build option: define COLUMN_APPROX_DIV_EXACT_EN to disable truncation (exact divider).
module column_approx_div #(
  parameter int LENGTH = 8,
  parameter int THETA  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  column_approx_div_if.slave  bus
);

  localparam int              QW    = 2 * LENGTH;
  localparam int              JW    = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [JW-1:0]   J_MAX = JW'(QW - 1);
  localparam logic [LENGTH:0] ONES  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Handshake decode
  logic accept;
  logic step;
  logic div_zero;

  // Operand / result registers. The partial remainder R is LENGTH+1 bits in the
  // algorithm, but R < y holds after every step so its top bit is always zero;
  // only the low LENGTH bits are stored and the shifted value R' is LENGTH+1 bits.
  logic [QW-1:0]     x_reg;
  logic [LENGTH-1:0] y_reg;
  logic [QW-1:0]     q_reg;
  logic [LENGTH-1:0] rem;
  logic [JW-1:0]     j;
  logic              dbz_reg;

  // One-step trial division signals
  logic [LENGTH:0]   r_shift;
  logic [LENGTH:0]   y_ext;
  logic [LENGTH:0]   mask;
  logic              q_bit;
  logic [LENGTH-1:0] rem_nxt;

  assign div_zero = (bus.y == '0);

  // State register; reset aborts any division in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs: accept only in IDLE, iterate in RUN, pulse done in DONE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = div_zero ? DONE : RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        step     = 1'b1;
        if (j == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // One quotient bit: shift in x[j], compare under the column mask, restore or subtract.
  always_comb begin
    r_shift = {rem, x_reg[j]};
    y_ext   = {1'b0, y_reg};
    mask    = ONES;
`ifndef COLUMN_APPROX_DIV_EXACT_EN
    // Below bit THETA, ignore the (THETA-j) lowest columns of both operands.
    if (int'(j) < THETA) begin
      mask = ONES << (THETA - int'(j));
    end
`endif
    q_bit = ((r_shift & mask) >= (y_ext & mask));
    if (q_bit) begin
      // A masked compare can say "fits" when R' < y; then the remainder collapses to 0
      // so R < y still holds for the next step.
      rem_nxt = (r_shift >= y_ext) ? LENGTH'(r_shift - y_ext) : '0;
    end else begin
      rem_nxt = r_shift[LENGTH-1:0];
    end
  end

  // Datapath registers: load on accept, advance one bit per RUN cycle, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg   <= '0;
      y_reg   <= '0;
      q_reg   <= '0;
      rem     <= '0;
      j       <= '0;
      dbz_reg <= 1'b0;
    end else if (accept) begin
      x_reg <= bus.x;
      y_reg <= bus.y;
      j     <= J_MAX;
      if (div_zero) begin
        q_reg   <= '1;
        rem     <= bus.x[LENGTH-1:0];
        dbz_reg <= 1'b1;
      end else begin
        q_reg   <= '0;
        rem     <= '0;
        dbz_reg <= 1'b0;
      end
    end else if (step) begin
      q_reg[j] <= q_bit;
      rem      <= rem_nxt;
      j        <= j - 1'b1;
    end
  end

  assign bus.q   = q_reg;
  assign bus.r   = rem;
  assign bus.dbz = dbz_reg;

endmodule

// File: tb/tb_column_approx_div.sv
// tb_column_approx_div: directed table plus handshake corner sequences for column_approx_div
// (LENGTH=8, THETA=4). Expectations switch on COLUMN_APPROX_DIV_EXACT_EN.
// Random section: exact build compares to integer division, approximate build checks bounds.
module tb_column_approx_div;

  localparam int LENGTH = 8;
  localparam int THETA  = 4;

  logic clk = 1'b0;
  logic rst_n;

  column_approx_div_if #(.LENGTH(LENGTH)) bus ();

  column_approx_div #(.LENGTH(LENGTH), .THETA(THETA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] x;
    logic [7:0]  y;
    logic [15:0] q_ex;
    logic [7:0]  r_ex;
    logic [15:0] q_ap;
    logic [7:0]  r_ap;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called at posedge+1 while idle; returns in the done cycle (or after the bound).
  task automatic do_div(input logic [15:0] xv, input logic [7:0] yv, output int lat);
    bus.x     = xv;
    bus.y     = yv;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          pulses;
    int          lat_done;
    logic [15:0] q_save;
    logic [7:0]  r_save;
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
    logic [15:0] rx;
    logic [7:0]  ry;
    int          qe;
    int          diff;

    tbl[0] = '{x: 16'd1000,   y: 8'd7,   q_ex: 16'd142,   r_ex: 8'd6, q_ap: 16'd143,   r_ap: 8'd0, dbz: 1'b0, lat: 17};
    tbl[1] = '{x: 16'd16,     y: 8'd3,   q_ex: 16'd5,     r_ex: 8'd1, q_ap: 16'd15,    r_ap: 8'd0, dbz: 1'b0, lat: 17};
    tbl[2] = '{x: 16'd255,    y: 8'd255, q_ex: 16'd1,     r_ex: 8'd0, q_ap: 16'd1,     r_ap: 8'd0, dbz: 1'b0, lat: 17};
    tbl[3] = '{x: 16'hFFFF,   y: 8'd1,   q_ex: 16'hFFFF,  r_ex: 8'd0, q_ap: 16'hFFFF,  r_ap: 8'd0, dbz: 1'b0, lat: 17};
    tbl[4] = '{x: 16'd100,    y: 8'd10,  q_ex: 16'd10,    r_ex: 8'd0, q_ap: 16'd11,    r_ap: 8'd0, dbz: 1'b0, lat: 17};
    tbl[5] = '{x: 16'd0,      y: 8'd5,   q_ex: 16'd0,     r_ex: 8'd0, q_ap: 16'd3,     r_ap: 8'd0, dbz: 1'b0, lat: 17};
    tbl[6] = '{x: 16'h1234,   y: 8'd0,   q_ex: 16'hFFFF,  r_ex: 8'h34, q_ap: 16'hFFFF, r_ap: 8'h34, dbz: 1'b1, lat: 1};

    // Reset state
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_q",    32'(bus.q),    0);
    check("reset_r",    32'(bus.r),    0);
    check("reset_dbz",  32'(bus.dbz),  0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
`ifdef COLUMN_APPROX_DIV_EXACT_EN
      exp_q = tbl[i].q_ex;
      exp_r = tbl[i].r_ex;
`else
      exp_q = tbl[i].q_ap;
      exp_r = tbl[i].r_ap;
`endif
      do_div(tbl[i].x, tbl[i].y, lat);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("tbl%0d_busy_done_cycle", i), 32'(bus.busy), 1);
      check($sformatf("tbl%0d_q", i), 32'(bus.q), 32'(exp_q));
      check($sformatf("tbl%0d_r", i), 32'(bus.r), 32'(exp_r));
      check($sformatf("tbl%0d_dbz", i), 32'(bus.dbz), 32'(tbl[i].dbz));
      @(posedge clk); #1;
      check($sformatf("tbl%0d_done_drop", i), 32'(bus.done), 0);
      check($sformatf("tbl%0d_busy_drop", i), 32'(bus.busy), 0);
      bus.x = 16'hA5A5;
      bus.y = 8'h3C;
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("tbl%0d_q_hold", i), 32'(bus.q), 32'(exp_q));
      check($sformatf("tbl%0d_r_hold", i), 32'(bus.r), 32'(exp_r));
    end

    // Start re-pulsed at cycle 5 of a run is ignored; done pulses once
`ifdef COLUMN_APPROX_DIV_EXACT_EN
    exp_q = 16'd142; exp_r = 8'd6;
`else
    exp_q = 16'd143; exp_r = 8'd0;
`endif
    bus.x = 16'd1000; bus.y = 8'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    pulses = 0; lat_done = 0; q_save = '0; r_save = '0;
    for (int c = 1; c < 30; c++) begin
      if (c == 5) begin
        bus.start = 1'b1; bus.x = 16'd16; bus.y = 8'd3;
      end
      if (c == 6) bus.start = 1'b0;
      if (bus.done) begin
        pulses++;
        if (pulses == 1) begin
          lat_done = c; q_save = bus.q; r_save = bus.r;
        end
      end
      @(posedge clk); #1;
    end
    check("midrun_start_done_pulses", 32'(pulses), 1);
    check("midrun_start_latency", 32'(lat_done), 17);
    check("midrun_start_q", 32'(q_save), 32'(exp_q));
    check("midrun_start_r", 32'(r_save), 32'(exp_r));

    // Start held through the done cycle is ignored there, accepted in the next IDLE cycle
    do_div(16'd16, 8'd3, lat);
    check("b2b_first_latency", 32'(lat), 17);
    bus.x = 16'd100; bus.y = 8'd10; bus.start = 1'b1;
    @(posedge clk); #1;
    check("b2b_done_cycle_start_ignored", 32'(bus.busy), 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_idle_start_accepted", 32'(bus.busy), 1);
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
`ifdef COLUMN_APPROX_DIV_EXACT_EN
    exp_q = 16'd10;
`else
    exp_q = 16'd11;
`endif
    check("b2b_second_latency", 32'(lat), 17);
    check("b2b_second_q", 32'(bus.q), 32'(exp_q));
    @(posedge clk); #1;

    // Asynchronous reset at cycle 8 of a run
    bus.x = 16'hFFFF; bus.y = 8'd1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("midrun_q_before_reset", 32'(bus.q), 32'h0000_FF00);
    check("midrun_busy_before_reset", 32'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", 32'(bus.busy), 0);
    check("async_reset_done", 32'(bus.done), 0);
    check("async_reset_q",    32'(bus.q),    0);
    check("async_reset_r",    32'(bus.r),    0);
    check("async_reset_dbz",  32'(bus.dbz),  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_div(16'd255, 8'd255, lat);
    check("post_reset_latency", 32'(lat), 17);
    check("post_reset_q", 32'(bus.q), 1);
    check("post_reset_r", 32'(bus.r), 0);
    @(posedge clk); #1;

    // Random dividends, divisors >= 16
    for (int k = 0; k < 1000; k++) begin
      rx = 16'($urandom_range(0, 65535));
      ry = 8'($urandom_range(16, 255));
      qe = int'(rx) / int'(ry);
      do_div(rx, ry, lat);
      check("rand_latency", 32'(lat), 17);
`ifdef COLUMN_APPROX_DIV_EXACT_EN
      check("rand_q_exact", 32'(bus.q), 32'(qe));
      check("rand_r_exact", 32'(bus.r), 32'(int'(rx) % int'(ry)));
`else
      diff = (int'(bus.q) > qe) ? int'(bus.q) - qe : qe - int'(bus.q);
      check("rand_r_below_y", 32'(bus.r < ry), 1);
      check("rand_q_error_bound", 32'(diff < (1 << THETA)), 1);
`endif
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
